// File: rtl/trimmed_mean_filter.sv
`timescale 1ns/1ps
`default_nettype none
// trimmed_mean_filter: sliding-window trimmed-mean filter (rank, drop TRIM at each end, floor-divide by KEEP).
// Optional median output enabled by defining TMF_MEDIAN_EN.  Rev 1.0
module trimmed_mean_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int WINDOW     = 5,
  parameter int TRIM       = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic                  primed
`ifdef TMF_MEDIAN_EN
  ,
  output logic [DATA_WIDTH-1:0] median
`endif
);

  localparam int KEEP   = WINDOW - 2*TRIM;
  localparam int SUM_W  = DATA_WIDTH + $clog2(WINDOW);
  localparam int PW     = $clog2(WINDOW);
  localparam int FW     = $clog2(WINDOW + 1);
  localparam int CW     = $clog2(SUM_W);

  localparam logic [PW-1:0]    LAST_IDX = PW'(WINDOW - 1);
  localparam logic [PW-1:0]    RANK_LO  = PW'(TRIM);
  localparam logic [PW-1:0]    RANK_HI  = PW'(WINDOW - 1 - TRIM);
  localparam logic [FW-1:0]    FULL     = FW'(WINDOW);
  localparam logic [CW-1:0]    DIV_LAST = CW'(SUM_W - 1);
  localparam logic [SUM_W-1:0] DIVISOR  = SUM_W'(KEEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RANK = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] win [WINDOW];
  logic [PW-1:0]         wptr;
  logic [FW-1:0]         fill;
  logic [FW-1:0]         fill_inc;
  logic [PW-1:0]         rank_idx;
  logic [CW-1:0]         div_cnt;
  logic [SUM_W-1:0]      acc;
  logic [SUM_W-1:0]      rem;

  logic [DATA_WIDTH-1:0] cur;
  logic [PW-1:0]         rank;
  logic                  in_keep;
  logic [SUM_W-1:0]      rem_sh;
  logic                  q_bit;
  logic [SUM_W-1:0]      rem_nxt;

  assign fill_inc     = (fill == FULL) ? fill : fill + FW'(1);
  assign sample_ready = (state == S_IDLE);
  assign primed       = (fill == FULL);

  // Rank of the current element; equal values order by buffer index so ranks form a permutation.
  always_comb begin
    cur  = win[rank_idx];
    rank = '0;
    for (int j = 0; j < WINDOW; j++) begin
      if ((win[j] < cur) || ((win[j] == cur) && (PW'(j) < rank_idx)))
        rank = rank + PW'(1);
    end
    in_keep = (rank >= RANK_LO) && (rank <= RANK_HI);
  end

  // Restoring divide step; rem MSB acts as the carry-out of the shift.
  always_comb begin
    rem_sh  = {rem[SUM_W-2:0], acc[SUM_W-1]};
    q_bit   = rem[SUM_W-1] | (rem_sh >= DIVISOR);
    rem_nxt = q_bit ? (rem_sh - DIVISOR) : rem_sh;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (sample_valid && (fill_inc == FULL)) state_next = S_RANK;
        S_RANK: if (rank_idx == LAST_IDX) state_next = S_DIV;
        S_DIV:  if (div_cnt == DIV_LAST) state_next = S_DONE;
        S_DONE: state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < WINDOW; k++) win[k] <= '0;
      wptr         <= '0;
      fill         <= '0;
      rank_idx     <= '0;
      div_cnt      <= '0;
      acc          <= '0;
      rem          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else if (flush) begin
      wptr         <= '0;
      fill         <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sample_valid) begin
            win[wptr] <= sample_in;
            wptr      <= (wptr == LAST_IDX) ? '0 : wptr + PW'(1);
            fill      <= fill_inc;
            acc       <= '0;
            rank_idx  <= '0;
          end
        end
        S_RANK: begin
          if (in_keep) acc <= acc + SUM_W'(cur);
          rank_idx <= rank_idx + PW'(1);
          div_cnt  <= '0;
          rem      <= '0;
        end
        S_DIV: begin
          rem     <= rem_nxt;
          acc     <= {acc[SUM_W-2:0], q_bit};
          div_cnt <= div_cnt + CW'(1);
        end
        S_DONE: begin
          result       <= acc[DATA_WIDTH-1:0];
          result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef TMF_MEDIAN_EN
  localparam logic [PW-1:0] RANK_MID = PW'((WINDOW - 1) / 2);
  logic [DATA_WIDTH-1:0] med_cand;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      med_cand <= '0;
      median   <= '0;
    end else if (!flush) begin
      if ((state == S_RANK) && (rank == RANK_MID)) med_cand <= cur;
      if (state == S_DONE) median <= med_cand;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_trimmed_mean_filter.sv
`timescale 1ns/1ps
// Scoreboard bench for trimmed_mean_filter: random and directed samples vs. a sort-based reference model.
module tb_trimmed_mean_filter;
  localparam int DW    = 8;
  localparam int W     = 5;
  localparam int T     = 1;
  localparam int KEEPV = W - 2*T;
  localparam int LAT   = W + DW + $clog2(W) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          primed;
`ifdef TMF_MEDIAN_EN
  logic [DW-1:0] median;
`endif

  trimmed_mean_filter #(.DATA_WIDTH(DW), .WINDOW(W), .TRIM(T)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .result       (result),
    .result_valid (result_valid),
    .primed       (primed)
`ifdef TMF_MEDIAN_EN
    ,
    .median       (median)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int value;
    int med;
    int acc_cyc;
  } exp_t;

  exp_t expq[$];
  int   model_q[$];
  int   last_result = 0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   just_triggered = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: sort the window, average the middle KEEP values, floor.
  function automatic void model_accept(int v);
    int   srt[W];
    int   sum;
    exp_t e;
    model_q.push_back(v);
    if (model_q.size() > W) void'(model_q.pop_front());
    just_triggered = 1'b0;
    if (model_q.size() == W) begin
      foreach (srt[i]) srt[i] = model_q[i];
      srt.sort();
      sum = 0;
      for (int i = T; i < W - T; i++) sum += srt[i];
      e.value   = sum / KEEPV;
      e.med     = srt[(W-1)/2];
      e.acc_cyc = cyc;
      expq.push_back(e);
      just_triggered = 1'b1;
    end
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      exp_t e;
      check("primed", int'(primed), int'(model_q.size() == W));
      if (result_valid) begin
        if (expq.size() == 0) begin
          check("spurious_result_valid", int'(result_valid), 0);
        end else begin
          e = expq.pop_front();
          check("result", int'(result), e.value);
          check("latency", cyc - e.acc_cyc, LAT);
`ifdef TMF_MEDIAN_EN
          check("median", int'(median), e.med);
`endif
          last_result = e.value;
        end
      end else begin
        check("result_hold", int'(result), last_result);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int v);
    int  waits = 0;
    bit  chk = just_triggered;
    sample_in    = DW'(v);
    sample_valid = 1'b1;
    while (!sample_ready && waits < 200) begin
      @(negedge clock);
      waits++;
    end
    if (!sample_ready) begin
      check("ready_timeout", int'(sample_ready), 1);
    end else begin
      if (chk) check("stall_cycles", waits, LAT);
      @(posedge clock);
      #1;
      model_accept(v);
      @(negedge clock);
    end
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
    just_triggered = 1'b0;
  endtask

  task automatic do_flush(input bit with_sample, input int v);
    sample_in    = DW'(v);
    sample_valid = with_sample;
    flush        = 1'b1;
    @(posedge clock);
    #1;
    model_q.delete();
    expq.delete();
    just_triggered = 1'b0;
    @(negedge clock);
    flush        = 1'b0;
    sample_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_ready", int'(sample_ready), 1);
    check("reset_result", int'(result), 0);
    check("reset_valid", int'(result_valid), 0);
    check("reset_primed", int'(primed), 0);

    // Directed windows
    send(10); send(200); send(30); send(40); send(50);
    send(60);
    repeat (5) send(7);
    repeat (5) send(255);
    send(1); send(2); send(2); send(3); send(100);
    send(0);

    // Random stream with occasional idle gaps
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 5))
        0: v = 0;
        1: v = 255;
        default: v = int'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 20)));
      send(v);
    end

    // Flush mid-RANK
    send(int'($urandom_range(0, 255)));
    @(negedge clock);
    do_flush(1'b0, 0);
    check("flush_primed", int'(primed), 0);
    check("flush_ready", int'(sample_ready), 1);
    for (int n = 0; n < 5; n++) send(int'($urandom_range(0, 255)));
    idle(25);

    // Flush wins over a simultaneous sample
    do_flush(1'b0, 0);
    for (int n = 0; n < 4; n++) send(int'($urandom_range(0, 255)));
    do_flush(1'b1, 99);
    for (int n = 0; n < 5; n++) send(int'($urandom_range(0, 255)));
    idle(25);

    // Reset mid-DIV
    for (int n = 0; n < 5; n++) send(int'($urandom_range(0, 255)));
    repeat (8) @(posedge clock);
    #2;
    reset = 1'b1;
    model_q.delete();
    expq.delete();
    last_result    = 0;
    just_triggered = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b0;
    @(negedge clock);
    check("midreset_result", int'(result), 0);
    check("midreset_primed", int'(primed), 0);
    check("midreset_ready", int'(sample_ready), 1);
    for (int n = 0; n < 5; n++) send(int'($urandom_range(0, 255)));
    send(128);

    for (int n = 0; n < 60 && expq.size() != 0; n++) @(negedge clock);
    check("drain", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trimmed_mean_filter.md
Name: trimmed_mean_filter

Overview:
Sliding-window outlier-rejecting filter for range samples.
- Holds the last WINDOW samples in a circular buffer.
- Ranks them sequentially, discards the TRIM lowest and TRIM highest, and outputs the truncated mean of the rest via a sequential divider.
- Sits between the sensor sample capture and the position/display logic.
- Generalised successor of the fixed 5-sample middle-3 selector: parametrised width, window and trim, with a handshake.

Parameters:
DATA_WIDTH, 8, sample width in bits.
WINDOW, 5, samples in the window; must be 3..16.
TRIM, 1, samples dropped at each end; 2*TRIM < WINDOW required.

Ports:
clock  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
flush  input  1  synchronous; clears window fill and aborts any computation.
sample_in  input  DATA_WIDTH  new sample.
sample_valid  input  1  sample_in is valid.
sample_ready  output  1  block can accept a sample.
result  output  DATA_WIDTH  trimmed mean, floor.
result_valid  output  1  one-cycle pulse when result updates.
primed  output  1  window holds WINDOW samples.

Behaviour:
- Derived values:
  - KEEP = WINDOW - 2*TRIM.
  - SUM_W = DATA_WIDTH + clog2(WINDOW).
  - Sum register and divider are SUM_W bits, so no overflow is possible.
- Reset (async, any state): state=IDLE, buffer cleared to 0, write pointer=0, fill count=0.
  - Outputs at reset: sample_ready=1, result=0, result_valid=0, primed=0.
- FSM states: IDLE, RANK, DIV, DONE.
- IDLE:
  - sample_ready=1; a sample is accepted on any edge where sample_valid=1.
  - On accept: write to buffer[wptr]; wptr wraps WINDOW-1 -> 0; fill count increments, saturating at WINDOW.
  - If the fill count (after update) equals WINDOW, go to RANK; otherwise stay in IDLE with no result.
  - primed=1 once fill count = WINDOW.
- RANK: WINDOW cycles, one element i per cycle.
  - rank(i) = number of j with buf[j] < buf[i], or buf[j] == buf[i] and j < i.
  - Ties therefore break by buffer index, and ranks form a permutation.
  - If TRIM <= rank(i) <= WINDOW-1-TRIM, add buf[i] to the sum.
  - Sum clears on entry to RANK.
- DIV:
  - Restoring divide of sum by constant KEEP, one quotient bit per cycle, SUM_W cycles.
  - Quotient is floor; remainder is discarded.
  - Quotient always fits DATA_WIDTH; the low DATA_WIDTH bits go to result.
- DONE: one cycle.
  - result register loads the quotient; result_valid=1 in this cycle only.
  - Next state IDLE.
- sample_ready=0 in RANK, DIV and DONE; samples offered then are not taken (held by the producer).
- Latency: result_valid is high exactly WINDOW + SUM_W + 1 cycles after the accepting edge.
  - Default configuration: 5 + 11 + 1 = 17 cycles.
- result holds its last value between pulses.
- flush=1 at any edge:
  - Clears fill count, wptr and primed; returns to IDLE; no result_valid.
  - result retains its old value.
  - flush has priority over a simultaneous sample accept, and that sample is dropped.
- Reset mid-RANK/DIV: the computation is aborted and all state is as at reset.

Optional Feature:
TMF_MEDIAN_EN:
- When defined, adds output median [DATA_WIDTH-1:0].
  - During RANK, latches buf[i] whose rank = (WINDOW-1)/2 (lower median for even WINDOW).
  - median updates in DONE together with result, and resets to 0.
- When undefined, the port and its logic are absent and all other behaviour is identical.

Test Plan:
- Defaults, samples 10,200,30,40,50 -> no result_valid for the first four; result=40 with result_valid 17 cycles after the fifth accept; primed=1; median=40 if enabled.
- Follow with 60 (replaces 10) -> window 200,30,40,50,60 -> result=50; wptr wrap verified.
- Ties 7,7,7,7,7 -> result=7; all-255 window -> result=255 (width/overflow check).
- Truncation 1,2,2,3,100 -> kept sum 7 / 3 -> result=2.
- Assert sample_valid continuously during RANK/DIV -> sample_ready=0 and the buffer is unchanged; exactly one sample is accepted per result cycle.
- Assert reset mid-DIV, and separately flush mid-RANK -> no result_valid, primed=0; the next 5 samples are needed before the next result. After reset result=0; after flush result keeps its prior value.
